uart_frame_loopback: RTL and testbench

Parametrised successor to the fixed 10000-byte collect/store/send loopback path. Accepts bytes from the UART receiver, buffers one frame of run-time-selectable length in internal memory, then returns it through the UART transmitter with a selectable transform (echo, invert, reverse order) and an optional trailing checksum. It runs entirely in the system clock domain, between the receiver/transmitter pair and the host-side control logic.

---
 rtl/uart_frame_loopback.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_frame_loopback.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loopback.sv
// uart_frame_loopback
// Collects one frame of UART words into an internal buffer, then replays the
// frame through the UART transmitter with an optional transform (echo, invert,
// reverse order) and an optional trailing checksum word.
module uart_frame_loopback #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 10000,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned APPEND_SUM = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic [ADDR_WIDTH-1:0] frame_len,
    input  logic [1:0]            mode,
    input  logic                  tx_ready,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  collect_done,
    output logic                  send_done,
    output logic                  overrun
);

    // Lengths and counters carry one extra bit so that a full DEPTH frame is
    // representable even when DEPTH == 2**ADDR_WIDTH.
    localparam int unsigned   LW      = ADDR_WIDTH + 1;
    localparam int unsigned   MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_LOAD,
        S_SEND_REQ,
        S_SEND_WAIT,
        S_SUM_REQ,
        S_SUM_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_valid_q;
    logic                  rx_held_q;
    logic [LW-1:0]         len_q, len_d;
    logic [1:0]            mode_q, mode_d;
    logic [LW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [LW-1:0]         rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  collect_done_q, collect_done_d;
    logic                  send_done_q, send_done_d;
    logic                  overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  mem_we;
    logic [MW-1:0]         mem_waddr;
    logic                  rd_en;
    logic [MW-1:0]         rd_addr;

    logic                  accept;
    logic [LW-1:0]         len_req;
    logic [LW-1:0]         len_eff;
    logic [DATA_WIDTH-1:0] word_out;
    logic [DATA_WIDTH-1:0] sum_out;

    // rx_held_q masks the first cycle after reset: a level that was already
    // high while in reset must not look like a fresh rising edge, even though
    // the edge register itself comes out of reset at 0.
    assign accept = rx_valid & ~rx_valid_q & ~rx_held_q;

    // Requested length, with 0 and out-of-range values mapped to a full buffer.
    always_comb begin
        len_req = {1'b0, frame_len};
        len_eff = len_req;
        if (len_req == '0 || len_req > DEPTH_L) begin
            len_eff = DEPTH_L;
        end
    end

    // Read address: forward order, or mirrored order for the reverse mode.
    always_comb begin
        if (mode_q == 2'b10) begin
            rd_addr = MW'(len_q - ONE_L - rd_idx_q);
        end else begin
            rd_addr = MW'(rd_idx_q);
        end
    end

    // Only the invert mode alters the payload; the checksum follows the same rule.
    assign word_out = (mode_q == 2'b01) ? ~rd_data_q : rd_data_q;
    assign sum_out  = (mode_q == 2'b01) ? ~sum_q     : sum_q;

    // Next-state, datapath updates and memory strobes for the frame sequencer.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        mode_d         = mode_q;
        wr_cnt_d       = wr_cnt_q;
        rd_idx_d       = rd_idx_q;
        sum_d          = sum_q;
        tx_start_d     = tx_start_q;
        tx_data_d      = tx_data_q;
        collect_done_d = 1'b0;
        send_done_d    = 1'b0;
        overrun_d      = overrun_q;
        mem_we         = 1'b0;
        mem_waddr      = '0;
        rd_en          = 1'b0;

        if (accept && (state_q inside {S_LOAD, S_SEND_REQ, S_SEND_WAIT,
                                       S_SUM_REQ, S_SUM_WAIT})) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    len_d     = len_eff;
                    mode_d    = mode;
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    sum_d     = rx_data;
                    wr_cnt_d  = ONE_L;
                    rd_idx_d  = '0;
                    overrun_d = 1'b0;
                    if (len_eff == ONE_L) begin
                        collect_done_d = 1'b1;
                        state_d        = S_LOAD;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = MW'(wr_cnt_q);
                    sum_d     = sum_q + rx_data;
                    wr_cnt_d  = wr_cnt_q + ONE_L;
                    if (wr_cnt_q + ONE_L == len_q) begin
                        collect_done_d = 1'b1;
                        state_d        = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                rd_en   = 1'b1;
                state_d = S_SEND_REQ;
            end

            S_SEND_REQ: begin
                tx_data_d = word_out;
                if (tx_ready) begin
                    tx_start_d = 1'b1;
                    state_d    = S_SEND_WAIT;
                end
            end

            S_SEND_WAIT: begin
                if (!tx_ready) begin
                    tx_start_d = 1'b0;
                    if (rd_idx_q < len_q - ONE_L) begin
                        rd_idx_d = rd_idx_q + ONE_L;
                        state_d  = S_LOAD;
                    end else if (APPEND_SUM != 0) begin
                        state_d = S_SUM_REQ;
                    end else begin
                        send_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_SUM_REQ: begin
                tx_data_d = sum_out;
                if (tx_ready) begin
                    tx_start_d = 1'b1;
                    state_d    = S_SUM_WAIT;
                end
            end

            S_SUM_WAIT: begin
                if (!tx_ready) begin
                    tx_start_d  = 1'b0;
                    send_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            rx_valid_q     <= 1'b0;
            rx_held_q      <= rx_valid;
            len_q          <= '0;
            mode_q         <= '0;
            wr_cnt_q       <= '0;
            rd_idx_q       <= '0;
            sum_q          <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
            collect_done_q <= 1'b0;
            send_done_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_valid_q     <= rx_valid;
            rx_held_q      <= 1'b0;
            len_q          <= len_d;
            mode_q         <= mode_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_idx_q       <= rd_idx_d;
            sum_q          <= sum_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
            collect_done_q <= collect_done_d;
            send_done_q    <= send_done_d;
            overrun_q      <= overrun_d;
        end
    end

    // Frame buffer: single write port, registered read port, contents kept over reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= rx_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign busy         = (state_q != S_IDLE);
    assign collect_done = collect_done_q;
    assign send_done    = send_done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_frame_loopback.sv
// tb_uart_frame_loopback
// Drives two instances (checksum on / off) with the same receiver traffic, each
// with its own transmitter model, and compares the transmitted words against a
// frame-level reference model.
module tb_uart_frame_loopback;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [4:0] frame_len;
    logic [1:0] mode;

    int tests    = 0;
    int fails    = 0;
    int rst_gen  = 0;
    int hold_cyc = 1;
    int busy_cyc = 1;

    logic [7:0] stim [32];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int unsigned AS = (g == 0) ? 1 : 0;

        logic        tx_ready;
        logic        tx_start;
        logic [7:0]  tx_data;
        logic        busy;
        logic        collect_done;
        logic        send_done;
        logic        overrun;
        logic [12:0] outs;
        logic [7:0]  got [1024];
        int          got_n  = 0;
        int          cd_cnt = 0;
        int          sd_cnt = 0;

        assign outs = {tx_start, tx_data, busy, collect_done, send_done, overrun};

        uart_frame_loopback #(
            .DATA_WIDTH(8),
            .DEPTH     (16),
            .ADDR_WIDTH(5),
            .APPEND_SUM(AS)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .rx_valid    (rx_valid),
            .rx_data     (rx_data),
            .frame_len   (frame_len),
            .mode        (mode),
            .tx_ready    (tx_ready),
            .tx_start    (tx_start),
            .tx_data     (tx_data),
            .busy        (busy),
            .collect_done(collect_done),
            .send_done   (send_done),
            .overrun     (overrun)
        );

        // Pulse counters for the done strobes.
        initial begin : mon
            forever begin
                @(negedge clk);
                if (collect_done === 1'b1) cd_cnt++;
                if (send_done === 1'b1) sd_cnt++;
            end
        end

        // Transmitter model: accepts a word on tx_start, stays ready for
        // hold_cyc cycles, then goes busy until the request drops plus busy_cyc.
        initial begin : txm
            logic [7:0] d;
            int         gen;
            bit         ab;
            tx_ready = 1'b1;
            forever begin
                @(negedge clk);
                if (rst === 1'b1 && tx_start === 1'b1) begin
                    d   = tx_data;
                    gen = rst_gen;
                    ab  = 1'b0;
                    if (got_n < 1024) got[got_n] = d;
                    got_n++;
                    for (int k = 0; k < hold_cyc; k++) begin
                        @(negedge clk);
                        if (rst_gen != gen) begin
                            ab = 1'b1;
                            break;
                        end
                        chk("tx_start_held", tx_start, 1);
                        chk("tx_data_stable", tx_data, d);
                    end
                    if (!ab) begin
                        tx_ready = 1'b0;
                        @(negedge clk);
                        if (rst_gen == gen) chk("tx_start_drop", tx_start, 0);
                        for (int k = 0; k < busy_cyc; k++) begin
                            @(negedge clk);
                            if (rst_gen != gen) break;
                            chk("tx_start_stall", tx_start, 0);
                        end
                    end
                    tx_ready = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: observed no completion, expected summary before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic wait_start();
        for (int c = 0; c < 400; c++) begin
            if (g_u[0].tx_start === 1'b1) break;
            @(negedge clk);
        end
        chk("tx_start_seen", g_u[0].tx_start, 1);
    endtask

    // Sends nb words from stim[], waits for both instances to finish and
    // compares the transmitted words with the frame-level expectation.
    task automatic run_frame(input int lenf, input int md, input int nb,
                             input int first_hold, input bit inject_ovr);
        int         b0, b1, cd0, cd1, sd0, sd1, L;
        logic [7:0] sum, w;
        logic [7:0] ex [17];
        b0  = g_u[0].got_n;  b1  = g_u[1].got_n;
        cd0 = g_u[0].cd_cnt; cd1 = g_u[1].cd_cnt;
        sd0 = g_u[0].sd_cnt; sd1 = g_u[1].sd_cnt;
        L   = (lenf == 0 || lenf > 16) ? 16 : lenf;

        sum = 8'h00;
        for (int i = 0; i < L; i++) sum = sum + stim[i];
        for (int i = 0; i < L; i++) begin
            w = (md == 2) ? stim[L - 1 - i] : stim[i];
            ex[i] = (md == 1) ? ~w : w;
        end
        ex[L] = (md == 1) ? ~sum : sum;

        frame_len = 5'(lenf);
        mode      = 2'(md);
        send_byte(stim[0], first_hold);
        chk("ovr_clear_a", g_u[0].overrun, 0);
        chk("ovr_clear_b", g_u[1].overrun, 0);
        if (L > 1) begin
            chk("one_accept_cd", g_u[0].cd_cnt - cd0, 0);
            chk("one_accept_busy", g_u[0].busy, 1);
        end
        for (int i = 1; i < nb; i++) send_byte(stim[i], $urandom_range(1, 3));

        if (inject_ovr) begin
            wait_start();
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            chk("overrun_set_a", g_u[0].overrun, 1);
            chk("overrun_set_b", g_u[1].overrun, 1);
        end

        for (int c = 0; c < 4000; c++) begin
            if (g_u[0].sd_cnt != sd0 && g_u[1].sd_cnt != sd1) break;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);

        chk("collect_done_a", g_u[0].cd_cnt - cd0, 1);
        chk("collect_done_b", g_u[1].cd_cnt - cd1, 1);
        chk("send_done_a", g_u[0].sd_cnt - sd0, 1);
        chk("send_done_b", g_u[1].sd_cnt - sd1, 1);
        chk("word_count_a", g_u[0].got_n - b0, L + 1);
        chk("word_count_b", g_u[1].got_n - b1, L);
        for (int i = 0; i <= L; i++) chk("word_a", g_u[0].got[b0 + i], ex[i]);
        for (int i = 0; i < L; i++) chk("word_b", g_u[1].got[b1 + i], ex[i]);
        chk("idle_a", g_u[0].busy, 0);
        chk("idle_b", g_u[1].busy, 0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
    endtask

    initial begin : main
        int L;
        rst       = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        frame_len = '0;
        mode      = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs_a", g_u[0].outs, 0);
        chk("reset_outs_b", g_u[1].outs, 0);
        rst = 1'b1;
        @(negedge clk);

        // Echo
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
        run_frame(4, 0, 4, 1, 1'b0);

        // Reverse, then invert
        stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03;
        run_frame(3, 2, 3, 1, 1'b0);
        run_frame(3, 1, 3, 1, 1'b0);

        // Length edges: 0 and oversize map to the full buffer; single word
        fill_random(16);
        run_frame(0, $urandom_range(0, 3), 16, 1, 1'b0);
        fill_random(16);
        run_frame(20, $urandom_range(0, 3), 16, 1, 1'b0);
        fill_random(1);
        run_frame(1, $urandom_range(0, 3), 1, 1, 1'b0);

        // rx_valid held high for 50 cycles counts once
        fill_random(2);
        run_frame(2, 0, 2, 50, 1'b0);

        // Transmitter keeps ready high 7 cycles after each start
        hold_cyc = 7;
        busy_cyc = 3;
        fill_random(5);
        run_frame(5, $urandom_range(0, 3), 5, 1, 1'b0);

        // Overrun during SEND_WAIT, sticky until the next frame start
        hold_cyc = 2;
        busy_cyc = 1;
        fill_random(4);
        run_frame(4, 0, 4, 1, 1'b1);
        chk("overrun_sticky_a", g_u[0].overrun, 1);
        chk("overrun_sticky_b", g_u[1].overrun, 1);
        fill_random(3);
        run_frame(3, 0, 3, 1, 1'b0);

        // Random frames
        repeat (4) begin
            L        = $urandom_range(1, 16);
            hold_cyc = $urandom_range(0, 3);
            busy_cyc = $urandom_range(0, 3);
            fill_random(L);
            run_frame(L, $urandom_range(0, 3), L, $urandom_range(1, 3), 1'b0);
        end

        // Reset mid-COLLECT with rx_valid high across the release
        hold_cyc  = 1;
        busy_cyc  = 1;
        frame_len = 5'd4;
        mode      = 2'b00;
        send_byte(8'h5A, 1);
        send_byte(8'hA5, 1);
        chk("collecting_busy", g_u[0].busy, 1);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        rst      = 1'b0;
        rst_gen++;
        @(negedge clk);
        chk("rst_collect_a", g_u[0].outs, 0);
        chk("rst_collect_b", g_u[1].outs, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("held_rx_ignored_a", g_u[0].busy, 0);
        chk("held_rx_ignored_b", g_u[1].busy, 0);
        rx_valid = 1'b0;
        @(negedge clk);

        // Reset mid-SEND_WAIT
        hold_cyc = 7;
        fill_random(3);
        frame_len = 5'd3;
        mode      = 2'b01;
        for (int i = 0; i < 3; i++) send_byte(stim[i], 1);
        wait_start();
        @(negedge clk);
        rst = 1'b0;
        rst_gen++;
        @(negedge clk);
        chk("rst_send_a", g_u[0].outs, 0);
        chk("rst_send_b", g_u[1].outs, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_send_idle", g_u[0].busy, 0);

        // A fresh 2-word frame after the aborts
        hold_cyc = 1;
        fill_random(2);
        run_frame(2, 2, 2, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
